preg_freelist_ctrl: RTL and testbench

- Physical-register allocation controller for the rename stage.
- Owns the circular free list of physical register IDs.
- Grants one free register per cycle to rename and accepts one released register per cycle from ROB commit.
- On FLUSH, runs a multi-cycle recovery FSM that rebuilds the free list from the RRAT in-use snapshot.

---
 rtl/preg_freelist_if.sv | 28 ++
 rtl/preg_freelist_ctrl.sv | 148 ++++++++++++++
 tb/tb_preg_freelist_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/preg_freelist_if.sv
// Rename/commit-side bus of the physical-register free-list controller.
// master: rename + commit logic; slave: the free-list controller.
interface preg_freelist_if #(
   parameter int PREG_W = 6
) ();
   logic              alloc_req;
   logic              alloc_grant;
   logic [PREG_W-1:0] alloc_reg;
   logic              release_valid;
   logic [PREG_W-1:0] release_reg;
   logic [PREG_W:0]   free_count;
   logic              empty;
   logic              recovering;
   logic              overflow_err;
   logic              dup_err;

   modport master (
      output alloc_req, release_valid, release_reg,
      input  alloc_grant, alloc_reg, free_count, empty, recovering,
             overflow_err, dup_err
   );

   modport slave (
      input  alloc_req, release_valid, release_reg,
      output alloc_grant, alloc_reg, free_count, empty, recovering,
             overflow_err, dup_err
   );
endinterface

// File: rtl/preg_freelist_ctrl.sv
// Physical-register free-list controller for the rename stage.
// Circular FIFO of free preg IDs: one grant and one release per cycle.
// FLUSH rebuilds the list from the RRAT in-use snapshot, one index per cycle.
// Optional macro FREELIST_CHECK_EN adds an is_free bitmap that drops
// duplicate releases and flags them on dup_err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal grant/release operation
// RECOVER | walking indices 1..NUM_PREGS-1, enqueueing non-RRAT pregs
module preg_freelist_ctrl #(
   parameter int NUM_PREGS = 64,
   parameter int PREG_W    = 6,
   parameter int NUM_AREGS = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 STALL,
   input  logic                 FLUSH,
   input  logic [NUM_PREGS-1:0] rrat_inuse,
   preg_freelist_if.slave       bus
);
   typedef enum logic {RUN, RECOVER} state_t;

   localparam logic [PREG_W:0]   FULL_CNT   = (PREG_W+1)'(NUM_PREGS);
   localparam logic [PREG_W:0]   RESET_CNT  = (PREG_W+1)'(NUM_PREGS - NUM_AREGS);
   localparam logic [PREG_W-1:0] RESET_TAIL = PREG_W'(NUM_PREGS - NUM_AREGS);
   localparam logic [PREG_W-1:0] LAST_IDX   = PREG_W'(NUM_PREGS - 1);

   state_t               state;
   logic [PREG_W-1:0]    fifo [NUM_PREGS];
   logic [PREG_W-1:0]    head;
   logic [PREG_W-1:0]    tail;
   logic [PREG_W-1:0]    walk_idx;
   logic [PREG_W:0]      count;
   logic [NUM_PREGS-1:0] snapshot;
   logic [NUM_PREGS-1:0] snap_next;
   logic                 recovering_q;
   logic                 overflow_q;
   logic                 grant;
   logic                 rel_hit;
   logic                 rel_ovf;
   logic                 rel_dup;
   logic                 rel_accept;
`ifdef FREELIST_CHECK_EN
   logic [NUM_PREGS-1:0] is_free;
   logic                 dup_q;
`endif

   // Grant/release qualification and the snapshot captured on FLUSH.
   always_comb begin
      snap_next = rrat_inuse;
      if (bus.release_valid) snap_next[bus.release_reg] = 1'b0;
      grant   = bus.alloc_req && (state == RUN) && !STALL && !FLUSH && (count != '0);
      rel_hit = bus.release_valid && (state == RUN) && !FLUSH && (bus.release_reg != '0);
      rel_ovf = rel_hit && (count == FULL_CNT);
`ifdef FREELIST_CHECK_EN
      rel_dup = rel_hit && !rel_ovf && is_free[bus.release_reg];
`else
      rel_dup = 1'b0;
`endif
      rel_accept = rel_hit && !rel_ovf && !rel_dup;
   end

   assign bus.alloc_grant  = grant;
   assign bus.alloc_reg    = fifo[head];
   assign bus.free_count   = count;
   assign bus.empty        = (count == '0);
   assign bus.recovering   = recovering_q;
   assign bus.overflow_err = overflow_q;
`ifdef FREELIST_CHECK_EN
   assign bus.dup_err      = dup_q;
`else
   assign bus.dup_err      = 1'b0;
`endif

   // FIFO, pointers and the RUN/RECOVER sequencer; FLUSH beats everything but RESET.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= RUN;
         head         <= '0;
         tail         <= RESET_TAIL;
         count        <= RESET_CNT;
         walk_idx     <= '0;
         snapshot     <= '0;
         recovering_q <= 1'b0;
         overflow_q   <= 1'b0;
         for (int i = 0; i < NUM_PREGS; i++) begin
            fifo[i] <= (i < NUM_PREGS - NUM_AREGS) ? PREG_W'(i + NUM_AREGS) : '0;
`ifdef FREELIST_CHECK_EN
            is_free[i] <= (i >= NUM_AREGS);
`endif
         end
`ifdef FREELIST_CHECK_EN
         dup_q <= 1'b0;
`endif
      end else if (FLUSH) begin
         state        <= RECOVER;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         snapshot     <= snap_next;
         walk_idx     <= PREG_W'(1);
         recovering_q <= 1'b1;
`ifdef FREELIST_CHECK_EN
         is_free      <= '0;
`endif
      end else begin
         case (state)
            RUN: begin
               if (grant) head <= head + 1'b1;
               if (rel_accept) begin
                  fifo[tail] <= bus.release_reg;
                  tail       <= tail + 1'b1;
               end
               case ({grant, rel_accept})
                  2'b10:   count <= count - 1'b1;
                  2'b01:   count <= count + 1'b1;
                  default: count <= count;
               endcase
               if (rel_ovf) overflow_q <= 1'b1;
`ifdef FREELIST_CHECK_EN
               if (grant)      is_free[fifo[head]]      <= 1'b0;
               if (rel_accept) is_free[bus.release_reg] <= 1'b1;
               if (rel_dup)    dup_q                    <= 1'b1;
`endif
            end
            RECOVER: begin
               if (!snapshot[walk_idx]) begin
                  fifo[tail] <= walk_idx;
                  tail       <= tail + 1'b1;
                  count      <= count + 1'b1;
`ifdef FREELIST_CHECK_EN
                  is_free[walk_idx] <= 1'b1;
`endif
               end
               if (walk_idx == LAST_IDX) begin
                  state        <= RUN;
                  recovering_q <= 1'b0;
               end else begin
                  walk_idx <= walk_idx + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// Directed bench for preg_freelist_ctrl: reset, allocation, release,
// recovery walk, restart, drops/errors, stall and reset during recovery.
module tb_preg_freelist_ctrl;
   localparam int NUM_PREGS = 64;
   localparam int PREG_W    = 6;
   localparam int NUM_AREGS = 32;

   logic                 CLK = 1'b0;
   logic                 RESET;
   logic                 STALL;
   logic                 FLUSH;
   logic [NUM_PREGS-1:0] rrat_inuse;
   int                   pass_cnt = 0;
   int                   total_cnt = 0;

   preg_freelist_if #(.PREG_W(PREG_W)) bus ();

   preg_freelist_ctrl #(
      .NUM_PREGS(NUM_PREGS), .PREG_W(PREG_W), .NUM_AREGS(NUM_AREGS)
   ) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .rrat_inuse(rrat_inuse), .bus(bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0; rrat_inuse = '0;
      bus.alloc_req = 1'b0; bus.release_valid = 1'b0; bus.release_reg = '0;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // Counts cycles with recovering high (sampled on negedge), bounded.
   task automatic wait_recover(output int cyc);
      cyc = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (!bus.recovering) break;
         cyc++;
      end
   endtask

   // Requests one grant per cycle and compares against the expected order.
   task automatic drain(input string name, input int exp_q[$]);
      bus.alloc_req = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge CLK);
         total_cnt++;
         if (bus.alloc_grant !== 1'b1 || bus.alloc_reg !== PREG_W'(exp_q[j]))
            $display("FAIL %s[%0d] grant=%0b reg=%0d want grant=1 reg=%0d",
                     name, j, bus.alloc_grant, bus.alloc_reg, exp_q[j]);
         else pass_cnt++;
         tick();
      end
      bus.alloc_req = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd32 || bus.alloc_reg !== 6'd32 || bus.empty !== 1'b0 ||
          bus.recovering !== 1'b0 || bus.alloc_grant !== 1'b0 ||
          bus.overflow_err !== 1'b0 || bus.dup_err !== 1'b0)
         $display("FAIL reset count=%0d reg=%0d empty=%0b rec=%0b grant=%0b ovf=%0b dup=%0b want 32/32/0/0/0/0/0",
                  bus.free_count, bus.alloc_reg, bus.empty, bus.recovering,
                  bus.alloc_grant, bus.overflow_err, bus.dup_err);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_alloc_all();
      int exp_q[$];
      for (int i = 32; i < 64; i++) exp_q.push_back(i);
      drain("alloc_all", exp_q);
      bus.alloc_req = 1'b1;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_grant !== 1'b0 || bus.empty !== 1'b1 || bus.free_count !== 7'd0)
         $display("FAIL alloc_exhausted grant=%0b empty=%0b count=%0d want 0/1/0",
                  bus.alloc_grant, bus.empty, bus.free_count);
      else pass_cnt++;
      tick();
      bus.alloc_req = 1'b0;
   endtask

   task automatic test_release_empty();
      bus.alloc_req = 1'b1; bus.release_valid = 1'b1; bus.release_reg = 6'd40;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_grant !== 1'b0)
         $display("FAIL no_bypass grant=%0b want 0", bus.alloc_grant);
      else pass_cnt++;
      tick();
      bus.release_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_grant !== 1'b1 || bus.alloc_reg !== 6'd40 || bus.free_count !== 7'd1)
         $display("FAIL release_then_grant grant=%0b reg=%0d count=%0d want 1/40/1",
                  bus.alloc_grant, bus.alloc_reg, bus.free_count);
      else pass_cnt++;
      tick();
      bus.alloc_req = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd0 || bus.empty !== 1'b1)
         $display("FAIL release_drained count=%0d empty=%0b want 0/1",
                  bus.free_count, bus.empty);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_recover();
      int cyc;
      int exp_q[$];
      rrat_inuse = 64'h0000_0000_FFFF_FFFF;
      rrat_inuse[5]  = 1'b0;
      rrat_inuse[45] = 1'b1;
      FLUSH = 1'b1; bus.alloc_req = 1'b1;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_grant !== 1'b0)
         $display("FAIL flush_no_grant grant=%0b want 0", bus.alloc_grant);
      else pass_cnt++;
      tick();
      FLUSH = 1'b0; bus.alloc_req = 1'b0;
      bus.release_valid = 1'b1; bus.release_reg = 6'd20;
      wait_recover(cyc);
      bus.release_valid = 1'b0;
      total_cnt++;
      if (cyc !== 63)
         $display("FAIL recover_cycles got %0d want 63", cyc);
      else pass_cnt++;
      total_cnt++;
      if (bus.free_count !== 7'd32)
         $display("FAIL recover_count got %0d want 32", bus.free_count);
      else pass_cnt++;
      tick();
      exp_q.push_back(5);
      for (int i = 32; i < 64; i++) if (i != 45) exp_q.push_back(i);
      drain("recover_order", exp_q);
   endtask

   task automatic test_flush_restart();
      int cyc;
      int exp_q[$];
      rrat_inuse = 64'h0000_0000_FFFF_FFFF;
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      repeat (9) tick();
      rrat_inuse = 64'h0000_0000_FFFF_FFFF;
      rrat_inuse[3] = 1'b0;
      FLUSH = 1'b1; bus.release_valid = 1'b1; bus.release_reg = 6'd7;
      tick();
      FLUSH = 1'b0; bus.release_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd0 || bus.recovering !== 1'b1)
         $display("FAIL restart_cleared count=%0d rec=%0b want 0/1",
                  bus.free_count, bus.recovering);
      else pass_cnt++;
      wait_recover(cyc);
      total_cnt++;
      if (cyc !== 62)
         $display("FAIL restart_cycles got %0d want 62", cyc);
      else pass_cnt++;
      total_cnt++;
      if (bus.free_count !== 7'd34)
         $display("FAIL restart_count got %0d want 34", bus.free_count);
      else pass_cnt++;
      tick();
      exp_q.push_back(3);
      exp_q.push_back(7);
      for (int i = 32; i < 64; i++) exp_q.push_back(i);
      drain("restart_order", exp_q);
   endtask

   task automatic test_release_zero_dup();
      bus.release_valid = 1'b1; bus.release_reg = 6'd0;
      tick();
      bus.release_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd0)
         $display("FAIL release_zero count=%0d want 0", bus.free_count);
      else pass_cnt++;
      bus.release_valid = 1'b1; bus.release_reg = 6'd50;
      tick();
      tick();
      bus.release_valid = 1'b0;
      @(negedge CLK);
`ifdef FREELIST_CHECK_EN
      total_cnt++;
      if (bus.free_count !== 7'd1 || bus.dup_err !== 1'b1 || bus.alloc_reg !== 6'd50)
         $display("FAIL dup_release count=%0d dup=%0b reg=%0d want 1/1/50",
                  bus.free_count, bus.dup_err, bus.alloc_reg);
      else pass_cnt++;
`else
      total_cnt++;
      if (bus.free_count !== 7'd2 || bus.dup_err !== 1'b0 || bus.alloc_reg !== 6'd50)
         $display("FAIL dup_release count=%0d dup=%0b reg=%0d want 2/0/50",
                  bus.free_count, bus.dup_err, bus.alloc_reg);
      else pass_cnt++;
`endif
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
`ifdef FREELIST_CHECK_EN
      bus.release_valid = 1'b1; bus.release_reg = 6'd40;
      tick();
      bus.release_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd32 || bus.dup_err !== 1'b1 || bus.overflow_err !== 1'b0)
         $display("FAIL dup_reset_free count=%0d dup=%0b ovf=%0b want 32/1/0",
                  bus.free_count, bus.dup_err, bus.overflow_err);
      else pass_cnt++;
`else
      bus.release_valid = 1'b1;
      for (int r = 1; r <= 32; r++) begin
         bus.release_reg = PREG_W'(r);
         tick();
      end
      bus.release_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd64 || bus.overflow_err !== 1'b0)
         $display("FAIL fill_full count=%0d ovf=%0b want 64/0",
                  bus.free_count, bus.overflow_err);
      else pass_cnt++;
      bus.release_valid = 1'b1; bus.release_reg = 6'd33;
      tick();
      bus.release_valid = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.free_count !== 7'd64 || bus.overflow_err !== 1'b1)
         $display("FAIL overflow count=%0d ovf=%0b want 64/1",
                  bus.free_count, bus.overflow_err);
      else pass_cnt++;
`endif
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      bus.alloc_req = 1'b1; STALL = 1'b1;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_grant !== 1'b0)
         $display("FAIL stall_grant grant=%0b want 0", bus.alloc_grant);
      else pass_cnt++;
      tick();
      STALL = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_grant !== 1'b1 || bus.alloc_reg !== 6'd32 || bus.free_count !== 7'd32)
         $display("FAIL stall_release grant=%0b reg=%0d count=%0d want 1/32/32",
                  bus.alloc_grant, bus.alloc_reg, bus.free_count);
      else pass_cnt++;
      tick();
      bus.alloc_req = 1'b0;
      @(negedge CLK);
      total_cnt++;
      if (bus.alloc_reg !== 6'd33 || bus.free_count !== 7'd31)
         $display("FAIL after_grant reg=%0d count=%0d want 33/31",
                  bus.alloc_reg, bus.free_count);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_recovery();
      rrat_inuse = '0;
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      repeat (5) tick();
      RESET = 1'b1;
      #2;
      total_cnt++;
      if (bus.recovering !== 1'b0 || bus.free_count !== 7'd32 || bus.alloc_reg !== 6'd32)
         $display("FAIL reset_mid_recover rec=%0b count=%0d reg=%0d want 0/32/32",
                  bus.recovering, bus.free_count, bus.alloc_reg);
      else pass_cnt++;
      tick();
      RESET = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_alloc_all();
      test_release_empty();
      test_recover();
      test_flush_restart();
      test_release_zero_dup();
      test_overflow();
      test_stall();
      test_reset_mid_recovery();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
